ysyx_25040129_mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter sharing the single memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). Only one transaction is outstanding at a time. Both sides use valid/ready request and response channels, matching the IFU/IDU/EXU handshake style. The arbiter also enforces a response timeout and returns an error to the requester when it expires.

---
 rtl/ysyx_25040129_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_25040129_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_mem_arbiter.sv
// ysyx_25040129_mem_arbiter
//   Two-master (IFU, LSU) to one-slave memory arbiter with a single
//   outstanding transaction. Round-robin grant on contention, registered
//   request payload toward the slave, combinational response forwarding
//   back to the owning master, and a response timeout that returns an
//   error to the owner.
//
// Parameters
//   TIMEOUT  cycles allowed in REQ+RESP before aborting (0 = no timeout)
//
// Ports
//   clk, rst                          clock, async active-high reset
//   ifu_req_valid/ready, ifu_addr     IFU request channel (read only)
//   ifu_resp_valid/ready, ifu_rdata,
//   ifu_resp_err                      IFU response channel
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wstrb     LSU request channel
//   lsu_resp_valid/ready, lsu_rdata,
//   lsu_resp_err                      LSU response channel
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wstrb     slave request channel
//   mem_resp_valid/ready, mem_rdata,
//   mem_resp_err                      slave response channel
module ysyx_25040129_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam bit          TOUT_EN  = (TIMEOUT != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        owner;        // 0 = IFU, 1 = LSU
  logic        last;         // owner of the most recent grant
  logic [15:0] cnt;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        accept;
  logic        owner_resp_ready;
  logic        tout_hit;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;

  // Grant: single requester wins outright; on a tie the master that was
  // not granted last time wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = last;
        grant_lsu = ~last;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready    = grant_ifu;
  assign lsu_req_ready    = grant_lsu;
  assign accept           = grant_ifu | grant_lsu;
  assign owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;
  // Fires only on the exact terminal count; a handshake completing on
  // that cycle takes priority over the abort.
  assign tout_hit         = TOUT_EN && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    out_valid      = 1'b0;
    out_rdata      = '0;
    out_err        = 1'b0;
    case (state)
      IDLE: begin
        mem_resp_ready = 1'b1;
        if (accept) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)  state_next = RESP;
        else if (tout_hit)  state_next = TOUT;
      end
      RESP: begin
        out_valid      = mem_resp_valid;
        out_rdata      = mem_rdata;
        out_err        = mem_resp_err;
        mem_resp_ready = owner_resp_ready;
        if (mem_resp_valid && owner_resp_ready) state_next = IDLE;
        else if (tout_hit)                      state_next = TOUT;
      end
      TOUT: begin
        out_valid      = 1'b1;
        out_err        = 1'b1;
        mem_resp_ready = 1'b1;
        if (owner_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the owner sees response traffic; the other master reads zeros.
  assign ifu_resp_valid = out_valid & ~owner;
  assign ifu_rdata      = owner ? '0 : out_rdata;
  assign ifu_resp_err   = out_err & ~owner;
  assign lsu_resp_valid = out_valid & owner;
  assign lsu_rdata      = owner ? out_rdata : '0;
  assign lsu_resp_err   = out_err & owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (state == IDLE && accept) begin
      owner <= grant_lsu;
      last  <= grant_lsu;
      cnt   <= '0;
      if (grant_lsu) begin
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wstrb <= lsu_wstrb;
      end else begin
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end
    end else if (state == REQ || state == RESP) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// tb_ysyx_25040129_mem_arbiter
//   Self-checking bench for ysyx_25040129_mem_arbiter (TIMEOUT = 4).
//   A transaction-level reference model (busy / slave-accepted / timed-out
//   flags plus an age count) predicts every output each cycle.
module tb_ysyx_25040129_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  ysyx_25040129_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, tracked by flags.
  bit          m_busy, m_own, m_last, m_sent, m_tout;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wstrb;

  int          cyc = 0;
  int          obs_cyc;
  bit          obs_ifu_acc, obs_lsu_acc, obs_ifu_rv, obs_ifu_err, obs_lsu_rv;
  logic [31:0] obs_ifu_rdata;

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 1; m_sent = 0; m_tout = 0; m_age = 0;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wstrb = '0;
  endtask

  // Called at a negedge with inputs already driven; compares, advances one
  // clock, returns at the following negedge. g = model grant (-1 none).
  task automatic step(output int g);
    bit          ordy, ev, ee;
    logic [31:0] ed;
    bit          done;
    #1;
    g = -1;
    if (!m_busy) begin
      if (ifu_req_valid && lsu_req_valid) g = m_last ? 0 : 1;
      else if (ifu_req_valid)             g = 0;
      else if (lsu_req_valid)             g = 1;
    end
    ordy = m_own ? lsu_resp_ready : ifu_resp_ready;
    ev = 0; ee = 0; ed = '0;
    if (m_busy && m_tout) begin
      ev = 1; ee = 1;
    end else if (m_busy && m_sent) begin
      ev = mem_resp_valid; ee = mem_resp_err; ed = mem_rdata;
    end
    check("ifu_req_ready", ifu_req_ready, g == 0);
    check("lsu_req_ready", lsu_req_ready, g == 1);
    check("mem_req_valid", mem_req_valid, m_busy && !m_sent && !m_tout);
    check("mem_resp_ready", mem_resp_ready, (!m_busy || m_tout) ? 1'b1 : (m_sent ? ordy : 1'b0));
    check("ifu_resp_valid", ifu_resp_valid, (m_busy && !m_own) ? ev : 1'b0);
    check("ifu_rdata", ifu_rdata, (m_busy && !m_own) ? ed : 32'h0);
    check("ifu_resp_err", ifu_resp_err, (m_busy && !m_own) ? ee : 1'b0);
    check("lsu_resp_valid", lsu_resp_valid, (m_busy && m_own) ? ev : 1'b0);
    check("lsu_rdata", lsu_rdata, (m_busy && m_own) ? ed : 32'h0);
    check("lsu_resp_err", lsu_resp_err, (m_busy && m_own) ? ee : 1'b0);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("mem_wen", mem_wen, m_wen);
    check("mem_wstrb", mem_wstrb, m_wstrb);
    obs_cyc       = cyc;
    obs_ifu_acc   = ifu_req_valid && ifu_req_ready;
    obs_lsu_acc   = lsu_req_valid && lsu_req_ready;
    obs_ifu_rv    = ifu_resp_valid;
    obs_ifu_err   = ifu_resp_err;
    obs_ifu_rdata = ifu_rdata;
    obs_lsu_rv    = lsu_resp_valid;
    @(posedge clk);
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1; m_own = (g == 1); m_last = (g == 1);
        m_sent = 0; m_tout = 0; m_age = 0;
        if (g == 1) begin
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wstrb = lsu_wstrb;
        end else begin
          m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wstrb = '0;
        end
      end
    end else if (m_tout) begin
      if (ordy) m_busy = 0;
    end else begin
      done = m_sent ? (mem_resp_valid && ordy) : mem_req_ready;
      if (done) begin
        if (m_sent) m_busy = 0;
        else        m_sent = 1;
      end else if (TO != 0 && m_age == int'(TO) - 1) begin
        m_tout = 1;
      end
      m_age++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int g;
    int grants[$];
    int acc_cyc[$];
    int ifu_first, lsu_first, acc, tcyc, busy_grants;
    bit slow;

    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; mem_resp_err = 0;
    model_reset();
    #3;
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_resp_ready", mem_resp_ready, 1'b1);
    check("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Contention with fast slave: IFU read then LSU store, alternating.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0413; mem_resp_err = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    ifu_first = -1; lsu_first = -1;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      step(g);
      if (obs_ifu_acc) begin grants.push_back(0); acc_cyc.push_back(obs_cyc); end
      if (obs_lsu_acc) begin grants.push_back(1); acc_cyc.push_back(obs_cyc); end
      if (obs_ifu_rv && ifu_first < 0) begin
        ifu_first = obs_cyc;
        check("ifu_read_rdata", obs_ifu_rdata, 32'h0000_0413);
        check("ifu_read_err", obs_ifu_err, 1'b0);
      end
      if (obs_lsu_rv && lsu_first < 0) lsu_first = obs_cyc;
    end
    check("grant_count", grants.size(), 4);
    while (grants.size() < 4) begin grants.push_back(-1); acc_cyc.push_back(-100); end
    check("grant0", grants[0], 0);
    check("grant1", grants[1], 1);
    check("grant2", grants[2], 0);
    check("grant3", grants[3], 1);
    check("throughput", acc_cyc[1] - acc_cyc[0], 3);
    check("ifu_latency", ifu_first - acc_cyc[0], 2);
    check("lsu_latency", lsu_first - acc_cyc[1], 2);
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (4) step(g);

    // Backpressure: slave stalls 3 cycles, LSU stalls response 2 cycles.
    lsu_req_valid = 1; lsu_addr = 32'h8000_2004; lsu_wen = 1;
    lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1100;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hAAAA_5555; lsu_resp_ready = 0;
    step(g);
    check("bp_accept", obs_lsu_acc, 1'b1);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    busy_grants = 0;
    repeat (3) begin
      step(g);
      busy_grants += int'(obs_ifu_acc) + int'(obs_lsu_acc);
    end
    mem_req_ready = 1;
    step(g);
    busy_grants += int'(obs_ifu_acc) + int'(obs_lsu_acc);
    mem_req_ready = 0;
    repeat (2) begin
      step(g);
      check("bp_resp_held", obs_lsu_rv, 1'b1);
      busy_grants += int'(obs_ifu_acc) + int'(obs_lsu_acc);
    end
    lsu_resp_ready = 1;
    step(g);
    busy_grants += int'(obs_ifu_acc) + int'(obs_lsu_acc);
    check("bp_no_second_grant", busy_grants, 0);
    lsu_req_valid = 0; ifu_req_valid = 0;
    mem_req_ready = 1; ifu_resp_ready = 1;
    repeat (8) step(g);

    // Timeout: slave never answers.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    mem_req_ready = 0; mem_resp_valid = 0; ifu_resp_ready = 0;
    acc = -100; tcyc = -1;
    for (int k = 0; k < 20 && tcyc < 0; k++) begin
      step(g);
      if (obs_ifu_acc) begin acc = obs_cyc; ifu_req_valid = 0; end
      if (obs_ifu_rv && obs_ifu_err && tcyc < 0) begin
        tcyc = obs_cyc;
        check("tout_rdata", obs_ifu_rdata, 32'h0);
      end
    end
    check("tout_latency", tcyc - acc, 5);
    step(g);
    check("tout_held", obs_ifu_rv, 1'b1);
    ifu_resp_ready = 1;
    step(g);
    mem_resp_valid = 1; mem_rdata = 32'hBAD0_0001;
    repeat (3) begin
      step(g);
      check("late_resp_ifu", obs_ifu_rv, 1'b0);
      check("late_resp_lsu", obs_lsu_rv, 1'b0);
    end

    // Randomized traffic, alternating fast and slow slave phases.
    ifu_req_valid = 0; lsu_req_valid = 0;
    for (int i = 0; i < 2000; i++) begin
      slow = ((i / 200) % 2) == 1;
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1; ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
        lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
      end
      mem_req_ready  = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mem_resp_valid = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      mem_rdata      = $urandom;
      mem_resp_err   = ($urandom_range(0, 7) == 0);
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
      step(g);
      if (g == 0) ifu_req_valid = 0;
      if (g == 1) lsu_req_valid = 0;
    end

    // Reset while in RESP, then check the first tie goes to the IFU.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200; lsu_req_valid = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_err = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int k = 0; k < 30 && !(m_busy && m_sent && !m_tout && !m_own); k++) begin
      step(g);
      if (g == 0) ifu_req_valid = 0;
    end
    check("reach_resp", m_busy && m_sent && !m_own, 1'b1);
    mem_resp_valid = 1; ifu_req_valid = 1; lsu_req_valid = 1;
    #2 rst = 1'b1;
    #1;
    check("midrst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check("midrst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    check("midrst_mem_req_valid", mem_req_valid, 1'b0);
    check("midrst_mem_resp_ready", mem_resp_ready, 1'b1);
    check("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(g);
    check("post_rst_ifu_grant", obs_ifu_acc, 1'b1);
    check("post_rst_lsu_grant", obs_lsu_acc, 1'b0);
    ifu_req_valid = 0;
    repeat (6) step(g);
    lsu_req_valid = 0;
    repeat (4) step(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
